// File: rtl/instruction_queue_if.sv
// Signal bundle between fetch/ROB/decoder and the instruction queue.
// The master side drives pushes, flush and idle; the slave side is the queue itself.
interface instruction_queue_if #(
  parameter int ADDR_W = 4
);
  logic              flush;
  logic              push_en;
  logic [31:0]       push_instruction;
  logic [16:0]       push_pc;
  logic [16:0]       push_jalr_prediction;
  logic              push_br_prediction;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              instruction_in;
  logic [31:0]       instruction;
  logic [16:0]       pc;
  logic [16:0]       jalr_prediction;
  logic              br_prediction;
  logic              idle;

  modport master (
    output flush, push_en, push_instruction, push_pc,
           push_jalr_prediction, push_br_prediction, idle,
    input  full, count, instruction_in, instruction, pc,
           jalr_prediction, br_prediction
  );

  modport slave (
    input  flush, push_en, push_instruction, push_pc,
           push_jalr_prediction, push_br_prediction, idle,
    output full, count, instruction_in, instruction, pc,
           jalr_prediction, br_prediction
  );
endinterface

// File: rtl/instruction_queue.sv
// Circular FIFO buffering fetched instructions plus PC and predictions for the decoder.
// The oldest entry is presented combinationally; a flush empties the queue in one cycle.
module instruction_queue #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter int FULL_MARGIN = 2
) (
  input logic                clk,
  input logic                rst,
  instruction_queue_if.slave q_if
);

  localparam logic [ADDR_W:0]   DEPTH_CNT   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   FULL_THRESH = (ADDR_W+1)'(DEPTH - FULL_MARGIN);
  localparam logic [ADDR_W:0]   CNT_ONE     = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE     = (ADDR_W)'(1);

  typedef struct packed {
    logic [31:0] instruction;
    logic [16:0] pc;
    logic [16:0] jalr_prediction;
    logic        br_prediction;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] tail_q, tail_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;

  logic   not_empty;
  logic   pop;
  logic   push_accept;
  logic   wr_en;
  entry_t wr_entry;
  entry_t head_entry;

  // A pop in the same cycle frees a slot, so a push at DEPTH is still accepted then.
  always_comb begin
    not_empty   = (count_q != '0);
    pop         = not_empty && q_if.idle;
    push_accept = q_if.push_en && ((count_q != DEPTH_CNT) || pop);

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    wr_en   = 1'b0;

    if (q_if.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      wr_en = push_accept;
      if (pop) begin
        head_d = head_q + PTR_ONE;
      end
      if (push_accept) begin
        tail_d = tail_q + PTR_ONE;
      end
      case ({push_accept, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    full_d = q_if.flush ? 1'b0 : (count_d >= FULL_THRESH);
  end

  always_comb begin
    wr_entry.instruction     = q_if.push_instruction;
    wr_entry.pc              = q_if.push_pc;
    wr_entry.jalr_prediction = q_if.push_jalr_prediction;
    wr_entry.br_prediction   = q_if.push_br_prediction;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[tail_q] <= wr_entry;
    end
  end

  always_comb begin
    head_entry = '0;
    if (not_empty) begin
      head_entry = mem_q[head_q];
    end
  end

  assign q_if.instruction_in  = not_empty;
  assign q_if.instruction     = head_entry.instruction;
  assign q_if.pc              = head_entry.pc;
  assign q_if.jalr_prediction = head_entry.jalr_prediction;
  assign q_if.br_prediction   = head_entry.br_prediction;
  assign q_if.full            = full_q;
  assign q_if.count           = count_q;

endmodule

// File: tb/tb_instruction_queue.sv
// Directed plus randomized bench for instruction_queue.
// A queue of packed entries serves as the reference FIFO.
module tb_instruction_queue;

  localparam int DEPTH       = 16;
  localparam int ADDR_W      = 4;
  localparam int FULL_MARGIN = 2;

  logic clk;
  logic rst;

  int compared   = 0;
  int mismatched = 0;
  int drops      = 0;

  logic [66:0] model_q [$];
  logic        model_full;

  instruction_queue_if #(.ADDR_W(ADDR_W)) q_if ();

  instruction_queue #(
    .DEPTH(DEPTH),
    .ADDR_W(ADDR_W),
    .FULL_MARGIN(FULL_MARGIN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .q_if(q_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [66:0] randEntry();
    return {32'($urandom()), 17'($urandom()), 17'($urandom()), 1'($urandom())};
  endfunction

  task automatic compareField(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic fl, input logic pe,
                               input logic id, input logic [66:0] e);
    rst                       = r;
    q_if.flush                = fl;
    q_if.push_en              = pe;
    q_if.idle                 = id;
    q_if.push_instruction     = e[66:35];
    q_if.push_pc              = e[34:18];
    q_if.push_jalr_prediction = e[17:1];
    q_if.push_br_prediction   = e[0];
  endtask

  task automatic checkOutput(input string where);
    logic [66:0] exp_head;
    exp_head = (model_q.size() != 0) ? model_q[0] : 67'd0;
    compareField({where, ".count"}, 67'(q_if.count), 67'(model_q.size()));
    compareField({where, ".instruction_in"}, 67'(q_if.instruction_in), 67'(model_q.size() != 0));
    compareField({where, ".full"}, 67'(q_if.full), 67'(model_full));
    compareField({where, ".instruction"}, 67'(q_if.instruction), 67'(exp_head[66:35]));
    compareField({where, ".pc"}, 67'(q_if.pc), 67'(exp_head[34:18]));
    compareField({where, ".jalr_prediction"}, 67'(q_if.jalr_prediction), 67'(exp_head[17:1]));
    compareField({where, ".br_prediction"}, 67'(q_if.br_prediction), 67'(exp_head[0]));
  endtask

  // Reference behaviour: reset beats flush, flush beats push/pop, pop frees a slot first.
  task automatic modelUpdate();
    bit do_pop;
    bit do_push;
    if (rst || q_if.flush) begin
      model_q.delete();
      model_full = 1'b0;
    end else begin
      do_pop  = (model_q.size() != 0) && q_if.idle;
      do_push = q_if.push_en && ((model_q.size() < DEPTH) || do_pop);
      if (q_if.push_en && !do_push) begin
        drops++;
        $display("[TB] protocol violation: push_en while queue holds %0d entries (dropped)",
                 model_q.size());
      end
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back({q_if.push_instruction, q_if.push_pc,
                                      q_if.push_jalr_prediction, q_if.push_br_prediction});
      model_full = (model_q.size() >= DEPTH - FULL_MARGIN);
    end
  endtask

  task automatic cycle(input string where);
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
    checkOutput(where);
  endtask

  initial begin
    model_full = 1'b0;

    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 67'd0);
    cycle("reset0");
    cycle("reset1");

    // Single push then zero-latency accept
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, {32'h00500093, 17'h00010, 17'h00000, 1'b0});
    cycle("push1");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 67'd0);
    cycle("pop1");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 67'd0);
    cycle("idle_empty");

    // Fill to full threshold, then to DEPTH, then a dropped push
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0,
                    {32'($urandom()), 17'(4 * i), 17'($urandom()), 1'($urandom())});
      cycle($sformatf("fill%0d", i));
    end
    for (int i = 14; i < 16; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0,
                    {32'($urandom()), 17'(4 * i), 17'($urandom()), 1'($urandom())});
      cycle($sformatf("fill%0d", i));
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, randEntry());
    cycle("drop_at_full");

    // Push and pop together while full: occupancy holds, pointers wrap
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1,
                    {32'($urandom()), 17'(17'h100 + 4 * i), 17'($urandom()), 1'($urandom())});
      cycle($sformatf("full_pushpop%0d", i));
    end

    // Random traffic, pushes suppressed only when they would be dropped
    for (int i = 0; i < 64; i++) begin
      logic id;
      logic pe;
      id = ($urandom_range(0, 3) != 0);
      pe = ($urandom_range(0, 3) != 0);
      if (model_q.size() == DEPTH && !id) pe = 1'b0;
      applyStimulus(1'b0, 1'b0, pe, id, randEntry());
      cycle($sformatf("rand%0d", i));
    end

    // Steer to 9 entries, then flush with push and pop requested
    for (int i = 0; i < 40 && model_q.size() != 9; i++) begin
      if (model_q.size() < 9) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, randEntry());
      else                    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 67'd0);
      cycle("to9");
    end
    compareField("reach9.count", 67'(q_if.count), 67'd9);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, randEntry());
    cycle("flush");
    compareField("flush.count_zero", 67'(q_if.count), 67'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, randEntry());
    cycle("post_flush_push");

    // Steer to 7 entries, then reset with a push pending
    for (int i = 0; i < 40 && model_q.size() != 7; i++) begin
      if (model_q.size() < 7) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, randEntry());
      else                    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 67'd0);
      cycle("to7");
    end
    compareField("reach7.count", 67'(q_if.count), 67'd7);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, randEntry());
    cycle("mid_reset");
    compareField("mid_reset.count_zero", 67'(q_if.count), 67'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, randEntry());
    cycle("post_reset_push");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 67'd0);
    cycle("post_reset_pop");

    $display("[TB] %0d pushes were dropped as protocol violations", drops);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
